// File: rtl/nfca_rx_tobits.sv
// NFC-A PICC->PCD bit decoder: classifies 24-sample bit periods from the ASK demodulator,
// assembles 9-bit characters (8 data + odd parity) and reports the frame end.
module nfca_rx_tobits #(
    parameter int HALF_LEN = 12,
    parameter int THRESH   = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_on,
    input  logic       rx_ask_en,
    input  logic       rx_ask,
    output logic       rx_byte_en,
    output logic [7:0] rx_byte,
    output logic       rx_byte_perr,
    output logic       rx_end,
    output logic [3:0] rx_end_bits,
    output logic       rx_end_col
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SOF  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [4:0] HALF_POS = 5'(HALF_LEN);
    localparam logic [4:0] LAST_POS = 5'(2 * HALF_LEN - 1);
    localparam logic [4:0] THR      = 5'(THRESH);

    // A correct ISO14443 character has odd weight over data+parity.
    function automatic logic parity_err(input logic [8:0] ch);
        return ~(^ch);
    endfunction

    state_t      state_r, state_nx_s;
    logic [4:0]  pos_r, pos_nx_s;
    logic [4:0]  cnt_a_r, cnt_a_nx_s, cnt_b_r, cnt_b_nx_s;
    logic [8:0]  bits_r, bits_nx_s, bits_ins_s;
    logic [3:0]  bitcnt_r, bitcnt_nx_s, bitcnt_inc_s;
    logic        col_r, col_nx_s;
    logic [4:0]  a_sum_s, b_sum_s;
    logic        hit_a_s, hit_b_s;
    logic        byte_en_r, byte_en_nx_s;
    logic [7:0]  byte_r, byte_nx_s;
    logic        perr_r, perr_nx_s;
    logic        end_r, end_nx_s;
    logic [3:0]  end_bits_r, end_bits_nx_s;
    logic        end_col_r, end_col_nx_s;

    // Next-state and output decode; only strobed samples move the decoder.
    always_comb begin
        state_nx_s    = state_r;
        pos_nx_s      = pos_r;
        cnt_a_nx_s    = cnt_a_r;
        cnt_b_nx_s    = cnt_b_r;
        bits_nx_s     = bits_r;
        bitcnt_nx_s   = bitcnt_r;
        col_nx_s      = col_r;
        byte_en_nx_s  = 1'b0;
        byte_nx_s     = byte_r;
        perr_nx_s     = perr_r;
        end_nx_s      = 1'b0;
        end_bits_nx_s = end_bits_r;
        end_col_nx_s  = end_col_r;

        a_sum_s      = cnt_a_r + {4'd0, (rx_ask && (pos_r <  HALF_POS))};
        b_sum_s      = cnt_b_r + {4'd0, (rx_ask && (pos_r >= HALF_POS))};
        hit_a_s      = (a_sum_s >= THR);
        hit_b_s      = (b_sum_s >= THR);
        bitcnt_inc_s = bitcnt_r + 4'd1;
        bits_ins_s   = bits_r;
        bits_ins_s[bitcnt_r] = hit_a_s;

        if (!rx_on) begin
            state_nx_s = S_IDLE;
            pos_nx_s   = 5'd0;
            cnt_a_nx_s = 5'd0;
            cnt_b_nx_s = 5'd0;
        end else if (rx_ask_en) begin
            case (state_r)
                S_IDLE: begin
                    if (rx_ask) begin
                        // This sample is pos 0 of the SOF bit.
                        state_nx_s = S_SOF;
                        pos_nx_s   = 5'd1;
                        cnt_a_nx_s = 5'd1;
                        cnt_b_nx_s = 5'd0;
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end
                S_SOF, S_DATA: begin
                    if (pos_r == LAST_POS) begin
                        pos_nx_s   = 5'd0;
                        cnt_a_nx_s = 5'd0;
                        cnt_b_nx_s = 5'd0;
                        if (state_r == S_SOF) begin
                            if (hit_a_s && !hit_b_s) begin
                                state_nx_s  = S_DATA;
                                bits_nx_s   = 9'd0;
                                bitcnt_nx_s = 4'd0;
                                col_nx_s    = 1'b0;
                            end else begin
                                state_nx_s = S_IDLE;
                            end
                        end else if (!hit_a_s && !hit_b_s) begin
                            state_nx_s    = S_IDLE;
                            end_nx_s      = 1'b1;
                            end_bits_nx_s = (bitcnt_r > 4'd8) ? 4'd8 : bitcnt_r;
                            byte_nx_s     = bits_r[7:0];
                            end_col_nx_s  = col_r;
                        end else begin
                            // Collision decodes as '1' and is remembered for the frame.
                            col_nx_s = col_r | (hit_a_s & hit_b_s);
                            if (bitcnt_inc_s == 4'd9) begin
                                byte_en_nx_s = 1'b1;
                                byte_nx_s    = bits_ins_s[7:0];
                                perr_nx_s    = parity_err(bits_ins_s);
                                bitcnt_nx_s  = 4'd0;
                                bits_nx_s    = 9'd0;
                            end else begin
                                bitcnt_nx_s = bitcnt_inc_s;
                                bits_nx_s   = bits_ins_s;
                            end
                        end
                    end else begin
                        pos_nx_s   = pos_r + 5'd1;
                        cnt_a_nx_s = a_sum_s;
                        cnt_b_nx_s = b_sum_s;
                    end
                end
                default: begin
                    state_nx_s = S_IDLE;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= S_IDLE;
            pos_r      <= 5'd0;
            cnt_a_r    <= 5'd0;
            cnt_b_r    <= 5'd0;
            bits_r     <= 9'd0;
            bitcnt_r   <= 4'd0;
            col_r      <= 1'b0;
            byte_en_r  <= 1'b0;
            byte_r     <= 8'd0;
            perr_r     <= 1'b0;
            end_r      <= 1'b0;
            end_bits_r <= 4'd0;
            end_col_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            pos_r      <= pos_nx_s;
            cnt_a_r    <= cnt_a_nx_s;
            cnt_b_r    <= cnt_b_nx_s;
            bits_r     <= bits_nx_s;
            bitcnt_r   <= bitcnt_nx_s;
            col_r      <= col_nx_s;
            byte_en_r  <= byte_en_nx_s;
            byte_r     <= byte_nx_s;
            perr_r     <= perr_nx_s;
            end_r      <= end_nx_s;
            end_bits_r <= end_bits_nx_s;
            end_col_r  <= end_col_nx_s;
        end
    end

    assign rx_byte_en   = byte_en_r;
    assign rx_byte      = byte_r;
    assign rx_byte_perr = perr_r;
    assign rx_end       = end_r;
    assign rx_end_bits  = end_bits_r;
    assign rx_end_col   = end_col_r;

endmodule

// File: tb/tb_nfca_rx_tobits.sv
// Bench for nfca_rx_tobits: frames are built from bit lists, sampled with random noise,
// and the observed byte/end reports are compared with a list-level frame model.
module tb_nfca_rx_tobits;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_on = 1'b0;
    logic       rx_ask_en = 1'b0;
    logic       rx_ask = 1'b0;
    logic       rx_byte_en;
    logic [7:0] rx_byte;
    logic       rx_byte_perr;
    logic       rx_end;
    logic [3:0] rx_end_bits;
    logic       rx_end_col;

    nfca_rx_tobits dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_on        (rx_on),
        .rx_ask_en    (rx_ask_en),
        .rx_ask       (rx_ask),
        .rx_byte_en   (rx_byte_en),
        .rx_byte      (rx_byte),
        .rx_byte_perr (rx_byte_perr),
        .rx_end       (rx_end),
        .rx_end_bits  (rx_end_bits),
        .rx_end_col   (rx_end_col)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0]  byte_q[$];   // {perr, byte}
    logic [12:0] end_q[$];    // {col, bits, byte}
    int kinds_q[$];           // 0='0', 1='1', 2=collision

    always @(negedge clk) begin
        if (rx_byte_en) byte_q.push_back({rx_byte_perr, rx_byte});
        if (rx_end) end_q.push_back({rx_end_col, rx_end_bits, rx_byte});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic v);
        @(negedge clk);
        rx_ask_en = 1'b1;
        rx_ask    = v;
        @(negedge clk);
        rx_ask_en = 1'b0;
        rx_ask    = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // Modulated half: subcarrier (1,1,0)x4 with random extra ones; otherwise at most 3 stray ones.
    task automatic half(input bit mod);
        int ones = 0;
        int k = $urandom_range(0, 3);
        for (int i = 0; i < 12; i++) begin
            logic s;
            if (mod) s = ((i % 3) != 2) || ($urandom_range(0, 3) == 0);
            else     s = (ones < k) && ($urandom_range(0, 3) == 0);
            if (s) ones++;
            strobe(s);
        end
    endtask

    task automatic send_bit(input int kind);
        case (kind)
            0:       begin half(1'b0); half(1'b1); end
            1:       begin half(1'b1); half(1'b0); end
            2:       begin half(1'b1); half(1'b1); end
            default: begin half(1'b0); half(1'b0); end
        endcase
    endtask

    task automatic load_byte(input logic [7:0] v, input bit par);
        for (int i = 0; i < 8; i++) kinds_q.push_back(int'(v[i]));
        kinds_q.push_back(int'(par));
    endtask

    task automatic send_body();
        byte_q.delete();
        end_q.delete();
        send_bit(1);
        foreach (kinds_q[i]) send_bit(kinds_q[i]);
    endtask

    task automatic send_frame();
        send_body();
        send_bit(3);
        repeat (4) strobe(1'b0);
    endtask

    // Frame model: 9-bit characters, then whatever bits remain form the partial byte.
    task automatic check_frame(input string tag);
        bit vals[$];
        bit col = 1'b0;
        int nb, rem;
        logic [7:0] eb;
        foreach (kinds_q[i]) begin
            vals.push_back(kinds_q[i] != 0);
            if (kinds_q[i] == 2) col = 1'b1;
        end
        nb  = vals.size() / 9;
        rem = vals.size() % 9;
        chk({tag, " nbytes"}, byte_q.size(), nb);
        for (int i = 0; i < nb && i < byte_q.size(); i++) begin
            int ones = 0;
            logic [7:0] b = 8'd0;
            for (int j = 0; j < 9; j++) begin
                if (vals[9*i+j]) ones++;
                if (j < 8) b[j] = vals[9*i+j];
            end
            chk({tag, " byte"}, byte_q[i][7:0], b);
            chk({tag, " perr"}, byte_q[i][8], (ones % 2) == 0);
        end
        chk({tag, " nends"}, end_q.size(), 1);
        eb = 8'd0;
        for (int j = 0; j < rem; j++) eb[j] = vals[9*nb+j];
        if (end_q.size() > 0) begin
            chk({tag, " end_byte"}, end_q[0][7:0], eb);
            chk({tag, " end_bits"}, end_q[0][11:8], rem);
            chk({tag, " end_col"}, end_q[0][12], col);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset outs", {rx_byte_en, rx_byte, rx_byte_perr, rx_end, rx_end_bits, rx_end_col}, 0);
        rstn = 1'b1;
        rx_on = 1'b1;
        repeat (2) strobe(1'b0);

        kinds_q.delete(); load_byte(8'h44, 1'b1); send_frame(); check_frame("b44");
        if (byte_q.size() > 0) chk("b44 const", byte_q[0], 9'h044);

        kinds_q.delete(); load_byte(8'h44, 1'b0); send_frame(); check_frame("b44perr");
        if (byte_q.size() > 0) chk("b44perr const", byte_q[0], 9'h144);

        kinds_q = '{1, 0, 1, 1}; send_frame(); check_frame("partial");
        if (end_q.size() > 0) chk("partial const", end_q[0], {1'b0, 4'd4, 8'h0D});

        kinds_q = '{0, 0, 2, 0, 0, 0, 0, 0, 0}; send_frame(); check_frame("collision");
        if (end_q.size() > 0) chk("collision col", end_q[0][12], 1'b1);

        kinds_q.delete(); for (int i = 0; i < 8; i++) kinds_q.push_back(1);
        send_frame(); check_frame("eight");

        kinds_q.delete(); send_frame(); check_frame("empty");

        // Single glitch in IDLE must be rejected as SOF noise.
        byte_q.delete(); end_q.delete();
        strobe(1'b1);
        repeat (30) strobe(1'b0);
        chk("glitch bytes", byte_q.size(), 0);
        chk("glitch ends", end_q.size(), 0);
        kinds_q.delete(); load_byte(8'h93, 1'b1); send_frame(); check_frame("after glitch");

        // rx_on dropped mid-byte: no pulses, strobes while off ignored.
        kinds_q = '{1, 1, 0, 1}; send_body();
        @(negedge clk); rx_on = 1'b0;
        repeat (5) strobe(1'b1);
        repeat (30) strobe(1'b0);
        rx_on = 1'b1;
        repeat (30) strobe(1'b0);
        chk("rx_on bytes", byte_q.size(), 0);
        chk("rx_on ends", end_q.size(), 0);
        kinds_q.delete(); load_byte(8'h5A, 1'b1); send_frame(); check_frame("after rx_on");

        // Async reset mid-frame after a byte has loaded rx_byte.
        kinds_q.delete(); load_byte(8'hA5, 1'b1); kinds_q.push_back(1); kinds_q.push_back(0);
        send_body();
        chk("pre-reset byte", byte_q.size(), 1);
        #2 rstn = 1'b0;
        #1 chk("async reset outs", {rx_byte_en, rx_byte, rx_byte_perr, rx_end, rx_end_bits, rx_end_col}, 0);
        @(negedge clk); rstn = 1'b1;
        byte_q.delete(); end_q.delete();
        repeat (30) strobe(1'b0);
        chk("reset no pulse", byte_q.size() + end_q.size(), 0);
        kinds_q.delete(); load_byte(8'h3C, 1'b1); send_frame(); check_frame("after reset");

        for (int f = 0; f < 6; f++) begin
            int len = $urandom_range(0, 20);
            kinds_q.delete();
            for (int i = 0; i < len; i++)
                kinds_q.push_back(($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1)));
            send_frame();
            check_frame($sformatf("rand%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nfca_rx_tobits.md
Name: nfca_rx_tobits

Overview:
- Downstream consumer of the ASK demodulator in the NFC-A receive path.
- Takes the demodulated sample stream (rx_ask_en/rx_ask, 2.5425 MSa/s, one strobe per 32 clk at 81.36 MHz) and decodes ISO14443-A PICC->PCD Manchester/subcarrier frames.
- Produces bytes with an odd-parity check, plus an end-of-frame report carrying partial-byte and collision information for the frame controller.
- Sampling math: 1 bit = 128/fc = 24 samples; half-bit = 12 samples (4 subcarrier cycles of 3 samples each).

Parameters:
- HALF_LEN, 12: samples per half-bit.
- THRESH, 4: minimum ask=1 samples in one half for that half to count as modulated.

Ports:
- clk  in  1  system clock, 81.36 MHz.
- rstn  in  1  asynchronous active-low reset.
- rx_on  in  1  receive window enable from the controller; 0 forces IDLE.
- rx_ask_en  in  1  sample strobe from the demodulator.
- rx_ask  in  1  demodulated sample; valid when rx_ask_en=1.
- rx_byte_en  out  1  one-clk pulse: rx_byte/rx_byte_perr valid.
- rx_byte  out  8  decoded byte, LSB received first; on rx_end it holds the partial byte.
- rx_byte_perr  out  1  parity of the 9 received bits is even (error).
- rx_end  out  1  one-clk pulse: frame ended.
- rx_end_bits  out  4  data bits in the trailing partial byte, 0..8; valid with rx_end.
- rx_end_col  out  1  at least one collision bit occurred in the frame; valid with rx_end.

Behaviour:
- Reset values (async, rstn=0): all outputs 0; state=IDLE; all counters and shift registers 0. Reset mid-frame discards the frame and produces no pulse.
- Only clocks with rx_ask_en=1 advance the decoder. All outputs are registered and pulse on the clk after the rx_ask_en that completes the event.
- Defaults: rx_byte_en and rx_end are 0 every clk unless set. rx_byte, rx_byte_perr, rx_end_bits and rx_end_col hold their last values.
- Per-bit accumulation:
  - pos counts 0..23 over one bit period.
  - cnt_a (5b) counts ask=1 samples at pos 0..11.
  - cnt_b (5b) counts ask=1 samples at pos 12..23.
  - At pos=23 the bit is classified; pos, cnt_a and cnt_b then clear.
- Classification, with A = cnt_a>=THRESH and B = cnt_b>=THRESH:
  - A & !B -> '1'.
  - !A & B -> '0'.
  - A & B -> collision: value '1', sets the sticky col flag.
  - !A & !B -> end-of-frame.
- State IDLE (rx_on=1): the first rx_ask=1 sample is taken as pos=0 of SOF, including that sample in cnt_a. Go to SOF.
- State SOF, at pos=23:
  - '1' -> DATA; bit buffer cleared, bitcnt=0, col=0.
  - Any other class -> IDLE silently (noise rejection, no outputs).
- State DATA, at pos=23:
  - '1', '0' or collision: shift the bit into the 9-bit buffer (LSB first) and bitcnt++.
  - When bitcnt reaches 9: pulse rx_byte_en; rx_byte = first 8 bits; rx_byte_perr = ~(XOR of all 9 bits); bitcnt=0.
  - end-of-frame: pulse rx_end; rx_end_bits = bitcnt clipped to 8; rx_byte = buffered bits right-aligned (upper bits 0); rx_end_col = col. Return to IDLE.
  - If bitcnt=0 at end, rx_byte = 0x00. If the end follows 8 data bits with no parity bit, rx_end_bits=8.
  - rx_byte_perr is left unchanged at end.
- A byte completion and an end can never occur on the same clk; end always takes a later bit period.
- rx_on=0 in any state: immediate synchronous return to IDLE, with no rx_end. rx_on=0 takes priority over a concurrent rx_ask_en.
- There is no frame-length limit; the controller bounds the frame with rx_on.
- Width rules: cnt_a and cnt_b saturate at 12 by construction (pos bounds); bitcnt is 4b.

Test Plan:
- Byte 0x44: with rx_on=1, send SOF = 12 samples of (1,1,0)x4 then 12 zeros. Then send bits 0,0,1,0,0,0,1,0, parity 1 (a '1' = modulated first half, a '0' = modulated second half). Then 24 zeros. Required: rx_byte_en once with rx_byte=0x44, perr=0; then rx_end with bits=0, col=0.
- Parity error: same stimulus with parity 0 -> rx_byte=0x44, rx_byte_perr=1.
- Partial byte: SOF, bits 1,0,1,1, then 24 zeros -> no rx_byte_en; rx_end with rx_end_bits=4, rx_byte=0x0D.
- Collision: SOF, then bit 2 modulated in both halves, byte 0x00 otherwise with parity per the rule -> rx_byte=0x04. Required: rx_end_col=1 at the end.
- Noise and enable:
  - A single rx_ask=1 glitch in IDLE then zeros -> no outputs; the next valid frame decodes.
  - rx_on=0 mid-byte -> no pulses.
- Async reset asserted mid-frame: all outputs 0 immediately; after release a fresh frame decodes correctly.
